// File: rtl/frame_loader.sv
// frame_loader: turns a valid/ready byte stream into sequential pixel writes
// for the frame buffer, one frame per start command, with a done pulse on the
// last pixel. Every output comes straight from a register.

`ifndef MODE_640X480X1BPPX60HZ
`define MODE_640X480X1BPPX60HZ 0
`endif
`ifndef MODE_640X480X2BPPX60HZ
`define MODE_640X480X2BPPX60HZ 1
`endif
`ifndef MODE_640X480X3BPPX60HZ
`define MODE_640X480X3BPPX60HZ 2
`endif

module frame_loader #(
  parameter int MODE         = `MODE_640X480X3BPPX60HZ,
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = $clog2(FRAME_PIXELS),
  localparam int BPP         = (MODE == `MODE_640X480X1BPPX60HZ) ? 1 :
                               (MODE == `MODE_640X480X2BPPX60HZ) ? 2 : 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [7:0]        data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [BPP-1:0]    wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] pixel_count_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   addr_s;
  logic                we_r;
  logic                we_s;
  logic                done_r;
  logic                done_s;
  logic [ADDR_W-1:0]   waddr_r;
  logic [BPP-1:0]      wdata_r;

  // State and pixel address register; reset drops any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
    end
  end

  // Next state, next address and write strobes; abort beats a valid byte.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    we_s    = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          state_s = ST_LOAD;
          addr_s  = {ADDR_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort_i) begin
          state_s = ST_IDLE;
          addr_s  = {ADDR_W{1'b0}};
        end else if (valid_i) begin
          we_s = 1'b1;
          if (addr_r == LAST_ADDR) begin
            done_s  = 1'b1;
            addr_s  = {ADDR_W{1'b0}};
            state_s = ST_IDLE;
          end else begin
            addr_s = addr_r + ADDR_ONE;
          end
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        addr_s  = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Write port registers: address/data update only on an accepted byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r    <= 1'b0;
      done_r  <= 1'b0;
      waddr_r <= {ADDR_W{1'b0}};
      wdata_r <= {BPP{1'b0}};
    end else begin
      we_r   <= we_s;
      done_r <= done_s;
      if (we_s) begin
        waddr_r <= addr_r;
        wdata_r <= data_i[BPP-1:0];
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign ready_o       = (state_r == ST_LOAD);
  assign busy_o        = (state_r == ST_LOAD);
  assign we_o          = we_r;
  assign done_o        = done_r;
  assign waddr_o       = waddr_r;
  assign wdata_o       = wdata_r;
  assign pixel_count_o = addr_r;

endmodule

// File: tb/tb_frame_loader.sv
// Bench for frame_loader: a 16-pixel 3bpp instance driven by directed and
// random traffic against a write-queue reference model, plus a 20-pixel
// 1bpp instance run through one full frame.

`ifndef MODE_640X480X1BPPX60HZ
`define MODE_640X480X1BPPX60HZ 0
`endif
`ifndef MODE_640X480X3BPPX60HZ
`define MODE_640X480X3BPPX60HZ 2
`endif

module tb_frame_loader;

  localparam int FP   = 16;
  localparam int BPP  = 3;
  localparam int AW   = $clog2(FP);
  localparam int FP_B = 20;
  localparam int AW_B = $clog2(FP_B);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i = 1'b1;
  logic          start_i = 1'b0, abort_i = 1'b0, valid_i = 1'b0;
  logic [7:0]    data_i = 8'h00;
  logic          ready_o, we_o, busy_o, done_o;
  logic [AW-1:0] waddr_o, pixel_count_o;
  logic [BPP-1:0] wdata_o;

  logic            start_b = 1'b0, abort_b = 1'b0, valid_b = 1'b0;
  logic [7:0]      data_b = 8'h00;
  logic            ready_b, we_b, busy_b, done_b;
  logic [AW_B-1:0] waddr_b, count_b;
  logic [0:0]      wdata_b;

  frame_loader #(.MODE(`MODE_640X480X3BPPX60HZ), .FRAME_PIXELS(FP)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .we_o(we_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .busy_o(busy_o), .done_o(done_o),
    .pixel_count_o(pixel_count_o)
  );

  frame_loader #(.MODE(`MODE_640X480X1BPPX60HZ), .FRAME_PIXELS(FP_B)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_b), .abort_i(abort_b),
    .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b), .we_o(we_b),
    .waddr_o(waddr_b), .wdata_o(wdata_b), .busy_o(busy_b), .done_o(done_b),
    .pixel_count_o(count_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: "loading" flag, pixels taken so far, last write seen.
  bit m_busy = 1'b0;
  int m_count = 0;
  int m_last_addr = 0;
  int m_last_data = 0;
  int m_frames = 0;

  // One clock of stimulus on the main instance, then check all its outputs.
  task automatic cycle(input bit r, input bit st, input bit ab, input bit v,
                       input logic [7:0] d);
    bit e_we;
    bit e_done;
    rst_i = r; start_i = st; abort_i = ab; valid_i = v; data_i = d;
    e_we = 1'b0;
    e_done = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_count = 0; m_last_addr = 0; m_last_data = 0;
    end else if (m_busy) begin
      if (ab) begin
        m_busy = 1'b0; m_count = 0;
      end else if (v) begin
        e_we = 1'b1;
        m_last_addr = m_count;
        m_last_data = int'(d) % (1 << BPP);
        m_count++;
        if (m_count == FP) begin
          e_done = 1'b1; m_busy = 1'b0; m_count = 0; m_frames++;
        end
      end
    end else if (st && !ab) begin
      m_busy = 1'b1; m_count = 0;
    end
    @(posedge clk);
    #1;
    chk("we", we_o, e_we);
    chk("waddr", waddr_o, m_last_addr);
    chk("wdata", wdata_o, m_last_data);
    chk("done", done_o, e_done);
    chk("busy", busy_o, m_busy);
    chk("ready", ready_o, m_busy);
    chk("pixcnt", pixel_count_o, m_count);
  endtask

  // Full frame on the 1bpp instance with random bytes.
  task automatic run_b();
    logic [7:0] d;
    int writes;
    int dones;
    writes = 0;
    dones = 0;
    start_b = 1'b1; valid_b = 1'b1; data_b = 8'hAA;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    chk("b_we_start", we_b, 0);
    chk("b_busy", busy_b, 1);
    for (int i = 0; i < FP_B; i++) begin
      d = 8'($urandom);
      valid_b = 1'b1; data_b = d;
      @(posedge clk);
      #1;
      chk("b_we", we_b, 1);
      chk("b_waddr", waddr_b, i);
      chk("b_wdata", wdata_b, d[0]);
      chk("b_done", done_b, (i == FP_B - 1) ? 1 : 0);
      writes += int'(we_b);
      dones += int'(done_b);
    end
    data_b = 8'hFF;
    @(posedge clk);
    #1;
    valid_b = 1'b0;
    chk("b_we_after", we_b, 0);
    chk("b_waddr_hold", waddr_b, FP_B - 1);
    chk("b_busy_after", busy_b, 0);
    chk("b_done_after", done_b, 0);
    chk("b_count", count_b, 0);
    chk("b_writes", writes, FP_B);
    chk("b_dones", dones, 1);
  endtask

  initial begin
    bit r, st, ab, v;

    // Reset, then bytes offered while idle are ignored.
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'h05);

    // Second instance, full 1bpp frame while the main one sits idle.
    run_b();

    // Back-to-back full-rate frame F0..FF.
    cycle(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < FP; i++) cycle(0, 0, 0, 1, 8'(8'hF0 + i));
    // Restart on the first idle cycle, valid toggling.
    cycle(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 2 * FP + 2; i++) cycle(0, 0, 0, (i % 2) == 0, 8'($urandom));

    // Abort after 5 bytes, coincident with a valid byte; then restart.
    cycle(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 8'(i + 8'h11));
    cycle(0, 0, 1, 1, 8'h77);
    cycle(0, 0, 0, 1, 8'h33);
    cycle(0, 1, 1, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'($urandom));

    // Start during LOAD ignored, then reset mid-frame.
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 8'($urandom));
    cycle(1, 0, 0, 1, 8'h99);
    cycle(0, 0, 0, 1, 8'h99);

    // Random traffic with occasional aborts and resets.
    for (int k = 0; k < 1200; k++) begin
      r  = ($urandom_range(0, 249) == 0);
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 3) != 0);
      cycle(r, st, ab, v, 8'($urandom));
    end

    chk("frames_seen", (m_frames >= 3) ? 1 : 0, 1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
